eeprom_cmd_seq: RTL and testbench
=================================

EEPROM_CMD_SEQ -- requirements
Module: eeprom_cmd_seq

Interface
REQ-001 Parameter TWR_GAP, default 16, idle cycles inserted after each completed byte operation (EEPROM write-cycle/bus recovery).
REQ-002 Parameter TIMEOUT, default 4095, maximum cycles WR/RD may be held without ACK before abort.
REQ-003 CLK  in  1  single clock; all logic on rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 START  in  1  one-cycle pulse; begins a burst when idle.
REQ-006 MODE  in  1  sampled with START; 0 = write burst, 1 = read burst.
REQ-007 BASE_ADDR  in  11  first byte address of the burst, sampled with START.
REQ-008 LEN  in  4  burst length, sampled with START; 1..15 = that many bytes, 0 = 16 bytes.
REQ-009 WDATA  in  8  host write byte.
REQ-010 WVALID  in  1  WDATA valid.
REQ-011 WREADY  out  1  sequencer accepts WDATA this cycle (transfer when WVALID & WREADY).
REQ-012 RDATA  out  8  byte read from EEPROM.
REQ-013 RVALID  out  1  one-cycle pulse, RDATA valid.
REQ-014 BUSY  out  1  high from cycle after accepted START until DONE.
REQ-015 DONE  out  1  one-cycle pulse at burst end (normal or aborted).
REQ-016 ERR  out  1  high with DONE when burst aborted on timeout; held until next accepted START.
REQ-017 WR  out  1  write request to EEPROM_WR.
REQ-018 RD  out  1  read request to EEPROM_WR.
REQ-019 ADDR  out  11  byte address to EEPROM_WR.
REQ-020 DATA  inout  8  parallel data bus to EEPROM_WR; driven by this block only in write operations, else high-Z.
REQ-021 ACK  in  1  end-of-operation acknowledge from EEPROM_WR.

Function
REQ-022 States: IDLE, LOAD, ISSUE, GAP, FIN; one-hot or binary encoding, implementer's choice.
REQ-023 IDLE: START=1 latches MODE/BASE_ADDR/LEN, loads byte counter, clears ERR; next state LOAD if MODE=0, ISSUE if MODE=1. START outside IDLE ignored.
REQ-024 LOAD (write only): WREADY=1; on WVALID=1 latch WDATA into data register, next ISSUE. No timeout in LOAD.
REQ-025 ISSUE: WR=1 (write) or RD=1 (read) held continuously; ADDR = current address; write drives DATA = data register throughout ISSUE.
REQ-026 ISSUE exit on ACK=1: WR/RD low and DATA high-Z from the next cycle; read captures DATA into RDATA in the ACK cycle and pulses RVALID the next cycle.
REQ-027 WR and RD never high simultaneously; each de-asserted for at least TWR_GAP cycles between operations.
REQ-028 GAP: count TWR_GAP cycles; then decrement byte counter; if bytes remain, increment address and go LOAD (write) or ISSUE (read), else FIN.
REQ-029 Address increment is modulo 2048 (0x7FF -> 0x000).
REQ-030 Timeout: cycle counter cleared on ISSUE entry; if TIMEOUT cycles elapse with ACK=0, drop WR/RD, set ERR, go FIN; remaining bytes discarded, no RVALID.
REQ-031 FIN: DONE=1 for one cycle, BUSY drops same cycle, next IDLE.
REQ-032 ACK outside ISSUE ignored.

Reset
REQ-033 RESET=1 at a clock edge forces IDLE from any state, including mid-ISSUE.
REQ-034 Reset values: WR=0, RD=0, ADDR=0, DATA high-Z, WREADY=0, RDATA=0, RVALID=0, BUSY=0, DONE=0, ERR=0; all counters 0.

Verification
REQ-035 Write burst: START, MODE=0, BASE_ADDR=0x010, LEN=3, bytes 0xA1,0xA2,0xA3, ACK 20 cycles after each WR -> three WR ops at 0x010/0x011/0x012 with DATA matching, >=16 idle cycles between, one DONE, ERR=0.
REQ-036 Read burst with wrap: MODE=1, BASE_ADDR=0x7FF, LEN=2, responder returns 0x5C then 0x3E -> RD at 0x7FF then 0x000, RVALID twice with RDATA 0x5C, 0x3E, DATA never driven.
REQ-037 LEN=0: read burst -> exactly 16 RD ops, 16 RVALID pulses, then DONE.
REQ-038 Timeout: write LEN=2, ACK never asserted -> WR low after 4095 cycles, DONE and ERR high same cycle, only one WR op issued.
REQ-039 Reset mid-ISSUE and START-while-busy: RESET during held RD -> next cycle RD=0, BUSY=0, DATA high-Z; START during a burst -> no effect on ADDR/LEN.

Source files
------------

// File: rtl/eeprom_cmd_seq.sv
// Burst command sequencer for a byte-wide parallel EEPROM write/read engine.
// Issues one WR/RD per byte, waits for ACK, enforces a recovery gap and a per-operation timeout.
module eeprom_cmd_seq #(
    parameter int TWR_GAP = 16,
    parameter int TIMEOUT = 4095
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        MODE,
    input  logic [10:0] BASE_ADDR,
    input  logic [3:0]  LEN,
    input  logic [7:0]  WDATA,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [7:0]  RDATA,
    output logic        RVALID,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic        WR,
    output logic        RD,
    output logic [10:0] ADDR,
    inout  wire  [7:0]  DATA,
    input  logic        ACK
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int GW = (TWR_GAP > 1) ? $clog2(TWR_GAP + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(TWR_GAP - 1);

    logic [2:0]    state_q,    state_d;
    logic          mode_q,     mode_d;
    logic [10:0]   addr_q,     addr_d;
    logic [4:0]    byte_cnt_q, byte_cnt_d;
    logic [7:0]    data_q,     data_d;
    logic [TW-1:0] tmo_q,      tmo_d;
    logic [GW-1:0] gap_q,      gap_d;
    logic          err_q,      err_d;
    logic [7:0]    rdata_q,    rdata_d;
    logic          rvalid_q,   rvalid_d;
    logic          wr_q,       wr_d;
    logic          rd_q,       rd_d;
    logic          wready_q,   wready_d;
    logic          busy_q,     busy_d;
    logic          done_q,     done_d;

    // Next-state, datapath and output decode; outputs are registered from the next state
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        addr_d     = addr_q;
        byte_cnt_d = byte_cnt_q;
        data_d     = data_q;
        tmo_d      = tmo_q;
        gap_d      = gap_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    mode_d     = MODE;
                    addr_d     = BASE_ADDR;
                    byte_cnt_d = (LEN == 4'd0) ? 5'd16 : {1'b0, LEN};
                    err_d      = 1'b0;
                    tmo_d      = '0;
                    state_d    = MODE ? S_ISSUE : S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (WVALID) begin
                    data_d  = WDATA;
                    tmo_d   = '0;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_ISSUE: begin
                if (ACK) begin
                    gap_d   = '0;
                    state_d = S_GAP;
                    if (mode_q) begin
                        rdata_d  = DATA;
                        rvalid_d = 1'b1;
                    end else begin
                        rvalid_d = 1'b0;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // Abort: the remaining bytes of the burst are dropped
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    tmo_d = tmo_q + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (byte_cnt_q == 5'd1) begin
                        byte_cnt_d = 5'd0;
                        state_d    = S_FIN;
                    end else begin
                        byte_cnt_d = byte_cnt_q - 5'd1;
                        addr_d     = addr_q + 11'd1;
                        tmo_d      = '0;
                        state_d    = mode_q ? S_ISSUE : S_LOAD;
                    end
                end else begin
                    gap_d = gap_q + {{(GW-1){1'b0}}, 1'b1};
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        wr_d     = (state_d == S_ISSUE) && !mode_d;
        rd_d     = (state_d == S_ISSUE) && mode_d;
        wready_d = (state_d == S_LOAD);
        busy_d   = (state_d == S_LOAD) || (state_d == S_ISSUE) || (state_d == S_GAP);
        done_d   = (state_d == S_FIN);
    end

    // Sequencer registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            addr_q     <= 11'd0;
            byte_cnt_q <= 5'd0;
            data_q     <= 8'd0;
            tmo_q      <= '0;
            gap_q      <= '0;
            err_q      <= 1'b0;
            rdata_q    <= 8'd0;
            rvalid_q   <= 1'b0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            wready_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            addr_q     <= addr_d;
            byte_cnt_q <= byte_cnt_d;
            data_q     <= data_d;
            tmo_q      <= tmo_d;
            gap_q      <= gap_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            wready_q   <= wready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // The bus is only driven while a write request is on the wire
    assign DATA   = wr_q ? data_q : 8'hzz;
    assign WR     = wr_q;
    assign RD     = rd_q;
    assign ADDR   = addr_q;
    assign WREADY = wready_q;
    assign RDATA  = rdata_q;
    assign RVALID = rvalid_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign ERR    = err_q;

endmodule

// File: tb/tb_eeprom_cmd_seq.sv
// Directed self-checking bench for eeprom_cmd_seq; the bench plays host and EEPROM responder.
module tb_eeprom_cmd_seq;

    logic        CLK = 1'b0;
    logic        RESET, START, MODE, WVALID, ACK;
    logic [10:0] BASE_ADDR;
    logic [3:0]  LEN;
    logic [7:0]  WDATA;
    logic        WREADY, RVALID, BUSY, DONE, ERR, WR, RD;
    logic [7:0]  RDATA;
    logic [10:0] ADDR;
    wire  [7:0]  DATA;
    logic        drv_en;
    logic [7:0]  drv_val;

    int checks   = 0;
    int failures = 0;

    assign DATA = drv_en ? drv_val : 8'hzz;

    always #5 CLK = ~CLK;

    eeprom_cmd_seq #(.TWR_GAP(16), .TIMEOUT(4095)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .MODE(MODE),
        .BASE_ADDR(BASE_ADDR), .LEN(LEN), .WDATA(WDATA), .WVALID(WVALID),
        .WREADY(WREADY), .RDATA(RDATA), .RVALID(RVALID), .BUSY(BUSY),
        .DONE(DONE), .ERR(ERR), .WR(WR), .RD(RD), .ADDR(ADDR),
        .DATA(DATA), .ACK(ACK)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_burst(input logic m, input logic [10:0] b, input logic [3:0] l);
        START = 1'b1; MODE = m; BASE_ADDR = b; LEN = l;
        tick();
        START = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        checks++;
        if ({WR, RD, WREADY, RVALID, BUSY, DONE, ERR} !== 7'b0)
            $display("FAIL reset_ctrl: got %b expected 0000000", {WR, RD, WREADY, RVALID, BUSY, DONE, ERR});
        checks++;
        if (ADDR !== 11'h000 || RDATA !== 8'h00)
            $display("FAIL reset_addr_rdata: got addr=%h rdata=%h expected 000/00", ADDR, RDATA);
        checks++;
        if (DATA !== 8'hzz && DATA !== 8'h00)
            $display("FAIL reset_bus: got %h expected undriven", DATA);
        if ({WR, RD, WREADY, RVALID, BUSY, DONE, ERR} !== 7'b0 || ADDR !== 11'h000 || RDATA !== 8'h00 ||
            (DATA !== 8'hzz && DATA !== 8'h00)) failures++;
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_write_burst();
        logic [7:0]  bytes [4];
        logic [10:0] exp_a;
        int idx, n_wr, n_done, wr_cyc, gap, cyc, extra;
        logic prev_wr;
        bytes[0] = 8'hA1; bytes[1] = 8'hA2; bytes[2] = 8'hA3; bytes[3] = 8'h00;
        idx = 0; n_wr = 0; n_done = 0; wr_cyc = 0; gap = 0; cyc = 0; extra = 0; prev_wr = 1'b0;
        start_burst(1'b0, 11'h010, 4'd3);
        checks++;
        if (BUSY !== 1'b1 || WREADY !== 1'b1) begin
            failures++; $display("FAIL wr_busy_wready: got busy=%b wready=%b expected 1/1", BUSY, WREADY);
        end
        while (n_done == 0 && cyc < 1000) begin
            if (WREADY && idx < 3) begin WVALID = 1'b1; WDATA = bytes[idx]; idx++; end
            else WVALID = 1'b0;
            if (WR) begin
                if (!prev_wr) begin
                    exp_a = 11'h010 + 11'(n_wr);
                    if (n_wr > 0) begin
                        checks++;
                        if (gap < 16) begin failures++; $display("FAIL wr_gap: got %0d expected >=16", gap); end
                    end
                    checks++;
                    if (ADDR !== exp_a) begin failures++; $display("FAIL wr_addr: got %h expected %h", ADDR, exp_a); end
                    checks++;
                    if (DATA !== bytes[(n_wr < 3) ? n_wr : 3]) begin
                        failures++; $display("FAIL wr_data: got %h expected %h", DATA, bytes[(n_wr < 3) ? n_wr : 3]);
                    end
                    n_wr++; wr_cyc = 0; gap = 0;
                end
                wr_cyc++;
                ACK = (wr_cyc == 20);
            end else begin
                ACK = 1'b0;
                if (prev_wr) begin
                    checks++;
                    if (DATA !== 8'hzz && DATA !== 8'h00) begin
                        failures++; $display("FAIL wr_release: got %h expected undriven", DATA);
                    end
                end
                gap++;
            end
            if (DONE) begin
                n_done++;
                checks++;
                if (ERR !== 1'b0 || BUSY !== 1'b0) begin
                    failures++; $display("FAIL wr_done_flags: got err=%b busy=%b expected 0/0", ERR, BUSY);
                end
            end
            prev_wr = WR;
            tick();
            cyc++;
        end
        WVALID = 1'b0; ACK = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (DONE || WR) extra++;
            tick();
        end
        checks++;
        if (n_wr !== 3 || n_done !== 1 || extra !== 0) begin
            failures++; $display("FAIL wr_counts: got ops=%0d done=%0d extra=%0d expected 3/1/0", n_wr, n_done, extra);
        end
    endtask

    task automatic test_read_wrap();
        logic [7:0]  resp [2];
        logic [10:0] exp_a;
        int n_rd, n_rv, n_done, rd_cyc, cyc;
        logic prev_rd, wr_seen;
        resp[0] = 8'h5C; resp[1] = 8'h3E;
        n_rd = 0; n_rv = 0; n_done = 0; rd_cyc = 0; cyc = 0; prev_rd = 1'b0; wr_seen = 1'b0;
        start_burst(1'b1, 11'h7FF, 4'd2);
        while (n_done == 0 && cyc < 500) begin
            if (RD) begin
                if (!prev_rd) begin
                    exp_a = 11'h7FF + 11'(n_rd);
                    checks++;
                    if (ADDR !== exp_a) begin failures++; $display("FAIL rd_addr: got %h expected %h", ADDR, exp_a); end
                    checks++;
                    if (DATA !== 8'hzz && DATA !== 8'h00) begin
                        failures++; $display("FAIL rd_bus_driven: got %h expected undriven", DATA);
                    end
                    n_rd++; rd_cyc = 0;
                end
                rd_cyc++;
                drv_en = 1'b1; drv_val = resp[(n_rd > 0 && n_rd <= 2) ? n_rd - 1 : 0];
                ACK = (rd_cyc == 3);
            end else begin
                ACK = 1'b0; drv_en = 1'b0;
            end
            if (RVALID) begin
                checks++;
                if (n_rv >= 2 || RDATA !== resp[(n_rv < 2) ? n_rv : 0]) begin
                    failures++; $display("FAIL rd_rdata: got %h expected %h (pulse %0d)", RDATA, resp[(n_rv < 2) ? n_rv : 0], n_rv);
                end
                n_rv++;
            end
            if (WR) wr_seen = 1'b1;
            if (DONE) n_done++;
            prev_rd = RD;
            tick();
            cyc++;
        end
        ACK = 1'b0; drv_en = 1'b0;
        checks++;
        if (n_rd !== 2 || n_rv !== 2 || n_done !== 1 || wr_seen !== 1'b0) begin
            failures++; $display("FAIL rd_counts: got rd=%0d rv=%0d done=%0d wr=%b expected 2/2/1/0", n_rd, n_rv, n_done, wr_seen);
        end
    endtask

    task automatic test_len0();
        logic [10:0] exp_a;
        logic [7:0]  exp_d;
        int n_rd, n_rv, n_done, rd_cyc, cyc, gap;
        logic prev_rd;
        n_rd = 0; n_rv = 0; n_done = 0; rd_cyc = 0; cyc = 0; gap = 0; prev_rd = 1'b0;
        start_burst(1'b1, 11'h3F8, 4'd0);
        while (n_done == 0 && cyc < 2000) begin
            if (RD) begin
                if (!prev_rd) begin
                    exp_a = 11'h3F8 + 11'(n_rd);
                    checks++;
                    if (ADDR !== exp_a) begin failures++; $display("FAIL len0_addr: got %h expected %h", ADDR, exp_a); end
                    if (n_rd > 0) begin
                        checks++;
                        if (gap < 16) begin failures++; $display("FAIL len0_gap: got %0d expected >=16", gap); end
                    end
                    n_rd++; rd_cyc = 0; gap = 0;
                end
                rd_cyc++;
                drv_en = 1'b1; drv_val = 8'h80 + 8'(n_rd - 1);
                ACK = (rd_cyc == 2);
            end else begin
                ACK = 1'b0; drv_en = 1'b0; gap++;
            end
            if (RVALID) begin
                exp_d = 8'h80 + 8'(n_rv);
                checks++;
                if (RDATA !== exp_d) begin failures++; $display("FAIL len0_rdata: got %h expected %h", RDATA, exp_d); end
                n_rv++;
            end
            if (DONE) n_done++;
            prev_rd = RD;
            tick();
            cyc++;
        end
        ACK = 1'b0; drv_en = 1'b0;
        checks++;
        if (n_rd !== 16 || n_rv !== 16 || n_done !== 1) begin
            failures++; $display("FAIL len0_counts: got rd=%0d rv=%0d done=%0d expected 16/16/1", n_rd, n_rv, n_done);
        end
    endtask

    task automatic test_timeout();
        int whi, n_rise, n_done, cyc;
        logic prev_wr;
        whi = 0; n_rise = 0; n_done = 0; cyc = 0; prev_wr = 1'b0;
        ACK = 1'b0;
        start_burst(1'b0, 11'h020, 4'd2);
        while (n_done == 0 && cyc < 6000) begin
            if (WREADY) begin WVALID = 1'b1; WDATA = 8'hC3; end
            else WVALID = 1'b0;
            if (WR && !prev_wr) n_rise++;
            if (WR) whi++;
            if (!WR && prev_wr) begin
                checks++;
                if (whi !== 4095) begin failures++; $display("FAIL tmo_len: got %0d expected 4095", whi); end
                checks++;
                if (DONE !== 1'b1 || ERR !== 1'b1) begin
                    failures++; $display("FAIL tmo_done_err: got done=%b err=%b expected 1/1", DONE, ERR);
                end
            end
            if (DONE) n_done++;
            prev_wr = WR;
            tick();
            cyc++;
        end
        WVALID = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (WR && !prev_wr) n_rise++;
            prev_wr = WR;
            tick();
        end
        checks++;
        if (n_rise !== 1 || n_done !== 1) begin
            failures++; $display("FAIL tmo_ops: got wr_ops=%0d done=%0d expected 1/1", n_rise, n_done);
        end
        checks++;
        if (ERR !== 1'b1 || BUSY !== 1'b0) begin
            failures++; $display("FAIL tmo_err_hold: got err=%b busy=%b expected 1/0", ERR, BUSY);
        end
    endtask

    task automatic test_reset_mid_issue();
        start_burst(1'b1, 11'h123, 4'd4);
        checks++;
        if (ERR !== 1'b0 || BUSY !== 1'b1) begin
            failures++; $display("FAIL start_clears_err: got err=%b busy=%b expected 0/1", ERR, BUSY);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (RD !== 1'b1 || ADDR !== 11'h123) begin
            failures++; $display("FAIL mid_rd_held: got rd=%b addr=%h expected 1/123", RD, ADDR);
        end
        RESET = 1'b1;
        tick();
        checks++;
        if (RD !== 1'b0 || BUSY !== 1'b0 || ADDR !== 11'h000) begin
            failures++; $display("FAIL mid_reset: got rd=%b busy=%b addr=%h expected 0/0/000", RD, BUSY, ADDR);
        end
        checks++;
        if (DATA !== 8'hzz && DATA !== 8'h00) begin
            failures++; $display("FAIL mid_reset_bus: got %h expected undriven", DATA);
        end
        RESET = 1'b0;
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        tick();
        checks++;
        if (RVALID !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0 || RD !== 1'b0) begin
            failures++; $display("FAIL idle_ack_ignored: got rvalid=%b busy=%b done=%b rd=%b expected 0/0/0/0", RVALID, BUSY, DONE, RD);
        end
    endtask

    task automatic test_start_while_busy();
        logic [10:0] exp_a;
        int n_rd, n_rv, n_done, rd_cyc, cyc;
        logic prev_rd, wr_seen;
        n_rd = 0; n_rv = 0; n_done = 0; rd_cyc = 0; cyc = 0; prev_rd = 1'b0; wr_seen = 1'b0;
        start_burst(1'b1, 11'h200, 4'd2);
        while (n_done == 0 && cyc < 500) begin
            START = (cyc % 5 == 2);
            MODE = 1'b0; BASE_ADDR = 11'h555; LEN = 4'd5;
            if (RD) begin
                if (!prev_rd) begin
                    exp_a = 11'h200 + 11'(n_rd);
                    checks++;
                    if (ADDR !== exp_a) begin failures++; $display("FAIL busy_start_addr: got %h expected %h", ADDR, exp_a); end
                    n_rd++; rd_cyc = 0;
                end
                rd_cyc++;
                drv_en = 1'b1; drv_val = 8'h11;
                ACK = (rd_cyc == 4);
            end else begin
                ACK = 1'b0; drv_en = 1'b0;
            end
            if (RVALID) n_rv++;
            if (WR || WREADY) wr_seen = 1'b1;
            if (DONE) begin n_done++; START = 1'b0; end
            prev_rd = RD;
            tick();
            cyc++;
        end
        START = 1'b0; ACK = 1'b0; drv_en = 1'b0;
        tick();
        checks++;
        if (n_rd !== 2 || n_rv !== 2 || n_done !== 1 || wr_seen !== 1'b0 || BUSY !== 1'b0) begin
            failures++; $display("FAIL busy_start_counts: got rd=%0d rv=%0d done=%0d wr=%b busy=%b expected 2/2/1/0/0",
                                 n_rd, n_rv, n_done, wr_seen, BUSY);
        end
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; MODE = 1'b0; BASE_ADDR = 11'h000; LEN = 4'd0;
        WDATA = 8'h00; WVALID = 1'b0; ACK = 1'b0; drv_en = 1'b0; drv_val = 8'h00;
        test_reset();
        test_write_burst();
        test_read_wrap();
        test_len0();
        test_timeout();
        test_reset_mid_issue();
        test_start_while_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
